// File: rtl/crg_rst_seq.sv
// crg_rst_seq: staged reset-release sequencer.
// Takes the synchronized reset request and releases NUM_STAGES active-low
// resets in order (bit 0 first). Consecutive releases are separated by
// stage_dly idle cycles. A new request re-asserts every released stage.
//
// Optional feature macro: CRG_RST_SEQ_REV_ASSERT_EN
//   undefined : a request clears all released stages at once (no ASSERT state)
//   defined   : a request clears released stages one per cycle, highest first
//
// state   | meaning
// HOLD    | all resets asserted, waiting for the request to drop
// RELEASE | counting down stage_dly, releasing one stage each time cnt hits 0
// DONE    | every stage released, no request pending
// ASSERT  | (feature only) clearing released stages in reverse order
module crg_rst_seq #(
    parameter int NUM_STAGES = 4,
    parameter int DLY_W      = 8
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  rst_req_sync,
    input  logic [DLY_W-1:0]      stage_dly,
    output logic [NUM_STAGES-1:0] rst_n_out,
    output logic                  seq_busy,
    output logic                  seq_done
);

    // idx must reach NUM_STAGES so the reverse-assert path knows how many are released
    localparam int IDX_W = $clog2(NUM_STAGES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

`ifdef CRG_RST_SEQ_REV_ASSERT_EN
    typedef enum logic [1:0] {HOLD, RELEASE, DONE, ASSERT} state_t;
`else
    typedef enum logic [1:0] {HOLD, RELEASE, DONE} state_t;
`endif

    state_t                state, state_nx;
    logic [DLY_W-1:0]      cnt, cnt_nx;
    logic [IDX_W-1:0]      idx, idx_nx;
    logic [NUM_STAGES-1:0] rst_nx;
    logic                  busy_nx, done_nx;
    logic [NUM_STAGES-1:0] rel_mask;
`ifdef CRG_RST_SEQ_REV_ASSERT_EN
    logic [NUM_STAGES-1:0] top_mask;
`endif

    // One-hot select of the stage to release next (and, with the feature, the highest released one)
    always_comb begin
        rel_mask = '0;
`ifdef CRG_RST_SEQ_REV_ASSERT_EN
        top_mask = '0;
`endif
        for (int i = 0; i < NUM_STAGES; i++) begin
            rel_mask[i] = (IDX_W'(i) == idx);
`ifdef CRG_RST_SEQ_REV_ASSERT_EN
            top_mask[i] = (IDX_W'(i + 1) == idx);
`endif
        end
    end

    // Next-state and next-output logic; every output is registered below
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        rst_nx   = rst_n_out;
        busy_nx  = seq_busy;
        done_nx  = seq_done;
        case (state)
            HOLD: begin
                rst_nx  = '0;
                busy_nx = 1'b0;
                done_nx = 1'b0;
                if (!rst_req_sync) begin
                    cnt_nx   = stage_dly;
                    idx_nx   = '0;
                    busy_nx  = 1'b1;
                    state_nx = RELEASE;
                end
            end
            RELEASE, DONE: begin
                if (rst_req_sync) begin
                    // A request wins over any release due on this edge
                    done_nx = 1'b0;
                    cnt_nx  = '0;
`ifdef CRG_RST_SEQ_REV_ASSERT_EN
                    if (idx == '0) begin
                        rst_nx   = '0;
                        busy_nx  = 1'b0;
                        state_nx = HOLD;
                    end else begin
                        busy_nx  = 1'b1;
                        state_nx = ASSERT;
                    end
`else
                    rst_nx   = '0;
                    idx_nx   = '0;
                    busy_nx  = 1'b0;
                    state_nx = HOLD;
`endif
                end else if (state == RELEASE) begin
                    if (cnt != '0) begin
                        cnt_nx = cnt - 1'b1;
                    end else begin
                        rst_nx = rst_n_out | rel_mask;
                        idx_nx = idx + 1'b1;
                        cnt_nx = stage_dly;
                        if (idx == LAST_IDX) begin
                            done_nx  = 1'b1;
                            busy_nx  = 1'b0;
                            state_nx = DONE;
                        end
                    end
                end
            end
`ifdef CRG_RST_SEQ_REV_ASSERT_EN
            ASSERT: begin
                // Released stages are contiguous from bit 0, so idx-1 is the highest one
                rst_nx = rst_n_out & ~top_mask;
                idx_nx = idx - 1'b1;
                if (idx <= IDX_W'(1)) begin
                    rst_nx   = '0;
                    idx_nx   = '0;
                    busy_nx  = 1'b0;
                    state_nx = HOLD;
                end
            end
`endif
            default: begin
                rst_nx   = '0;
                busy_nx  = 1'b0;
                done_nx  = 1'b0;
                state_nx = HOLD;
            end
        endcase
    end

    // State and output registers, synchronous clear
    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= HOLD;
            cnt       <= '0;
            idx       <= '0;
            rst_n_out <= '0;
            seq_busy  <= 1'b0;
            seq_done  <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            idx       <= idx_nx;
            rst_n_out <= rst_nx;
            seq_busy  <= busy_nx;
            seq_done  <= done_nx;
        end
    end

endmodule

// File: tb/tb_crg_rst_seq.sv
// tb_crg_rst_seq: scoreboard bench for crg_rst_seq (NUM_STAGES=4, DLY_W=8).
// Expected {rst_n_out, seq_busy, seq_done} are queued with the edge number
// at which they must hold, and popped/compared 1 ns after that edge.
module tb_crg_rst_seq;

    logic       clk = 1'b0;
    logic       clr;
    logic       req;
    logic [7:0] dly;
    logic [3:0] rst_n;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    crg_rst_seq #(.NUM_STAGES(4), .DLY_W(8)) dut (
        .clk          (clk),
        .clr          (clr),
        .rst_req_sync (req),
        .stage_dly    (dly),
        .rst_n_out    (rst_n),
        .seq_busy     (busy),
        .seq_done     (done)
    );

    typedef struct {
        int         at;
        logic [3:0] rst;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_at(input int at, input logic [3:0] r, input logic b, input logic d);
        exp_t e;
        e.at = at; e.rst = r; e.busy = b; e.done = d;
        sb.push_back(e);
    endtask

    // One clock edge, then compare every queued entry that is due
    task automatic step();
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            check($sformatf("rst_n@%0d", e.at), {28'b0, rst_n}, {28'b0, e.rst});
            check($sformatf("busy@%0d", e.at),  {31'b0, busy},  {31'b0, e.busy});
            check($sformatf("done@%0d", e.at),  {31'b0, done},  {31'b0, e.done});
        end
    endtask

    task automatic run_to(input int e);
        while (cyc < e) step();
    endtask

    // Expected release timeline for a request dropping at edge t with delay d
    task automatic push_release(input int t, input int d);
        if (d > 0) expect_at(t + d, 4'h0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++)
            expect_at(t + (k + 1) * (d + 1), 4'((1 << (k + 1)) - 1), (k != 3), (k == 3));
    endtask

    // Raise the request from DONE and check the stages come back down
    task automatic req_assert();
        int r;
        req = 1'b1;
        r = cyc + 1;
`ifdef CRG_RST_SEQ_REV_ASSERT_EN
        expect_at(r + 1, 4'h7, 1'b1, 1'b0);
        expect_at(r + 2, 4'h3, 1'b1, 1'b0);
        expect_at(r + 3, 4'h1, 1'b1, 1'b0);
        expect_at(r + 4, 4'h0, 1'b0, 1'b0);
`else
        expect_at(r, 4'h0, 1'b0, 1'b0);
`endif
        expect_at(r + 6, 4'h0, 1'b0, 1'b0);
        run_to(r + 6);
    endtask

    initial begin
        int t;
        clr = 1'b1;
        req = 1'b0;
        dly = 8'd3;

        // clr held two cycles with the request already low
        expect_at(1, 4'h0, 1'b0, 1'b0);
        expect_at(2, 4'h0, 1'b0, 1'b0);
        run_to(2);
        clr = 1'b0;

        // Basic sequence, stage_dly=3, starting at the first edge out of clr
        t = cyc + 1;
        push_release(t, 3);
        expect_at(t + 20, 4'hF, 1'b0, 1'b1);
        run_to(t + 20);

        req_assert();

        // stage_dly=0: one stage per cycle
        dly = 8'd0;
        req = 1'b0;
        t = cyc + 1;
        push_release(t, 0);
        expect_at(t + 6, 4'hF, 1'b0, 1'b1);
        run_to(t + 6);

        req_assert();

        // One-cycle request after stage 1 is released aborts and restarts
        dly = 8'd3;
        req = 1'b0;
        t = cyc + 1;
        expect_at(t + 8, 4'h3, 1'b1, 1'b0);
        run_to(t + 8);
        req = 1'b1;
`ifdef CRG_RST_SEQ_REV_ASSERT_EN
        expect_at(t + 9,  4'h3, 1'b1, 1'b0);
        expect_at(t + 10, 4'h1, 1'b1, 1'b0);
        expect_at(t + 11, 4'h0, 1'b0, 1'b0);
        expect_at(t + 15, 4'h0, 1'b1, 1'b0);
        expect_at(t + 16, 4'h1, 1'b1, 1'b0);
        expect_at(t + 28, 4'hF, 1'b0, 1'b1);
        step();
        req = 1'b0;
        run_to(t + 28);
`else
        expect_at(t + 9,  4'h0, 1'b0, 1'b0);
        expect_at(t + 10, 4'h0, 1'b1, 1'b0);
        expect_at(t + 13, 4'h0, 1'b1, 1'b0);
        expect_at(t + 14, 4'h1, 1'b1, 1'b0);
        expect_at(t + 26, 4'hF, 1'b0, 1'b1);
        step();
        req = 1'b0;
        run_to(t + 26);
`endif

        req_assert();

        // stage_dly changed 3 -> 1 mid-count only affects the next load
        dly = 8'd3;
        req = 1'b0;
        t = cyc + 1;
        run_to(t + 2);
        dly = 8'd1;
        expect_at(t + 4,  4'h1, 1'b1, 1'b0);
        expect_at(t + 5,  4'h1, 1'b1, 1'b0);
        expect_at(t + 6,  4'h3, 1'b1, 1'b0);
        expect_at(t + 7,  4'h3, 1'b1, 1'b0);
        expect_at(t + 8,  4'h7, 1'b1, 1'b0);
        expect_at(t + 10, 4'hF, 1'b0, 1'b1);
        run_to(t + 10);

        req_assert();

        // clr in the middle of a sequence wins over everything
        dly = 8'd2;
        req = 1'b0;
        t = cyc + 1;
        expect_at(t + 3, 4'h1, 1'b1, 1'b0);
        run_to(t + 4);
        clr = 1'b1;
        expect_at(t + 5, 4'h0, 1'b0, 1'b0);
        step();
        clr = 1'b0;
        req = 1'b1;
        expect_at(t + 7, 4'h0, 1'b0, 1'b0);
        run_to(t + 7);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
